// File: rtl/kan_tda_input_frame_loader.sv
// Word-serial to parallel frame loader with two ping-pong banks.
// Short frames are zero-padded and long frames truncated, so every presented frame is full.
module kan_tda_input_frame_loader #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_WORDS = 256,
  parameter int IDX_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_last,
  output logic [FRAME_WORDS*DATA_WIDTH-1:0] frame_data,
  output logic                              frame_valid,
  input  logic                              frame_ack,
  output logic                              short_frame,
  output logic                              long_frame,
  output logic [15:0]                       frames_done
);

  typedef enum logic [1:0] {FILL, PAD, DISCARD} state_t;

  state_t                 state, state_next;
  logic [DATA_WIDTH-1:0]  bank [2][FRAME_WORDS];
  logic [1:0]             full, full_next;
  logic                   fill_bank, fill_next;
  logic                   rd_bank, rd_next;
  logic [IDX_WIDTH-1:0]   wr_idx, wr_idx_next;
  logic                   short_next, long_next, ready_next;
  logic                   wr_en, complete, accept, last_idx;
  logic [DATA_WIDTH-1:0]  wr_word;

  assign accept   = s_valid & s_ready;
  assign last_idx = (wr_idx == IDX_WIDTH'(FRAME_WORDS - 1));

  always_comb begin
    state_next  = state;
    wr_idx_next = wr_idx;
    fill_next   = fill_bank;
    rd_next     = rd_bank;
    full_next   = full;
    short_next  = 1'b0;
    long_next   = 1'b0;
    wr_en       = 1'b0;
    wr_word     = s_data;
    complete    = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          wr_en       = 1'b1;
          wr_idx_next = wr_idx + 1'b1;
          if (last_idx) begin
            complete = 1'b1;
            if (!s_last) begin
              state_next = DISCARD;
              long_next  = 1'b1;
            end
          end else if (s_last) begin
            state_next = PAD;
            short_next = 1'b1;
          end
        end
      end
      PAD: begin
        wr_en       = 1'b1;
        wr_word     = '0;
        wr_idx_next = wr_idx + 1'b1;
        if (last_idx) begin
          complete   = 1'b1;
          state_next = FILL;
        end
      end
      DISCARD: begin
        if (accept && s_last) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
    // Ack and completion always target different banks, so both can apply.
    if (frame_ack && full[rd_bank]) begin
      full_next[rd_bank] = 1'b0;
      rd_next            = ~rd_bank;
    end
    if (complete) begin
      full_next[fill_bank] = 1'b1;
      fill_next            = ~fill_bank;
    end
    ready_next = (state_next == DISCARD) || ((state_next == FILL) && !full_next[fill_next]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      wr_idx      <= '0;
      fill_bank   <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= 2'b00;
      s_ready     <= 1'b0;
      frame_valid <= 1'b0;
      short_frame <= 1'b0;
      long_frame  <= 1'b0;
      frames_done <= 16'd0;
    end else begin
      state       <= state_next;
      wr_idx      <= wr_idx_next;
      fill_bank   <= fill_next;
      rd_bank     <= rd_next;
      full        <= full_next;
      s_ready     <= ready_next;
      frame_valid <= full_next[rd_next];
      short_frame <= short_next;
      long_frame  <= long_next;
      if (complete) frames_done <= frames_done + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < FRAME_WORDS; w++) begin
          bank[b][w] <= '0;
        end
      end
    end else if (wr_en) begin
      bank[fill_bank][wr_idx] <= wr_word;
    end
  end

  for (genvar gi = 0; gi < FRAME_WORDS; gi++) begin : g_word
    assign frame_data[gi*DATA_WIDTH +: DATA_WIDTH] = bank[rd_bank][gi];
  end

endmodule

// File: tb/tb_kan_tda_input_frame_loader.sv
// Directed bench for the ping-pong frame loader: normal, short, long, backpressure,
// ack coincidence, stray ack and mid-frame reset.
module tb_kan_tda_input_frame_loader;

  localparam int DW = 16;
  localparam int FW = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_data = '0;
  logic            s_last = 1'b0;
  logic [FW*DW-1:0] frame_data;
  logic            frame_valid;
  logic            frame_ack = 1'b0;
  logic            short_frame;
  logic            long_frame;
  logic [15:0]     frames_done;

  int vectors = 0;
  int miscompares = 0;
  int short_cnt = 0;
  int long_cnt = 0;
  int stall_cnt = 0;
  logic [DW-1:0] exp_mem [FW];

  kan_tda_input_frame_loader #(.DATA_WIDTH(DW), .FRAME_WORDS(FW), .IDX_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .frame_data(frame_data), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .short_frame(short_frame), .long_frame(long_frame), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (short_frame) short_cnt++;
    if (long_frame) long_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last, input bit ack);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = last; frame_ack = ack;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    stall_cnt += n;
    if (!s_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; frame_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input bit incr, input int n, input bit ack_last);
    for (int i = 0; i < n; i++)
      send(incr ? base + DW'(i) : base, i == n - 1, ack_last && (i == n - 1));
    idle();
  endtask

  task automatic ack_pulse();
    @(negedge clk); frame_ack = 1'b1;
    @(posedge clk);
    @(negedge clk); frame_ack = 1'b0;
  endtask

  task automatic set_exp(input logic [DW-1:0] base, input bit incr, input int n_valid);
    for (int j = 0; j < FW; j++)
      exp_mem[j] = (j < n_valid) ? (incr ? base + DW'(j) : base) : '0;
  endtask

  task automatic check_frame(input string tag);
    for (int j = 0; j < FW; j++)
      check($sformatf("%s_w%0d", tag, j), 32'(frame_data[j*DW +: DW]), 32'(exp_mem[j]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int pad;
    // reset state
    #3;
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_done", 32'(frames_done), 32'd0);
    check("rst_short", 32'(short_frame), 32'd0);
    check("rst_long", 32'(long_frame), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", 32'(s_ready), 32'd1);

    // normal frame F0 into bank0
    send_frame(16'h0000, 1'b1, FW, 1'b0);
    $display("frame F0 loaded, frames_done=%0d", frames_done);
    check("f0_valid", 32'(frame_valid), 32'd1);
    check("f0_done", 32'(frames_done), 32'd1);
    check("f0_ready", 32'(s_ready), 32'd1);
    set_exp(16'h0000, 1'b1, FW);
    check_frame("f0");

    // F1 into bank1: both banks full
    send_frame(16'hFFFF, 1'b0, FW, 1'b0);
    $display("frame F1 loaded, frames_done=%0d", frames_done);
    check("f1_ready_bp", 32'(s_ready), 32'd0);
    check("f1_done", 32'(frames_done), 32'd2);
    check("f1_valid", 32'(frame_valid), 32'd1);
    check_frame("f0_stable");

    // ack F0: F1 presented next, room freed
    ack_pulse();
    $display("ack F0");
    check("ack0_valid", 32'(frame_valid), 32'd1);
    check("ack0_ready", 32'(s_ready), 32'd1);
    set_exp(16'hFFFF, 1'b0, FW);
    check_frame("f1");

    // F2 into bank0, ack F1 on the same edge as F2's last word
    send_frame(16'h1000, 1'b1, FW, 1'b1);
    $display("frame F2 loaded with coincident ack");
    check("coin_valid", 32'(frame_valid), 32'd1);
    check("coin_done", 32'(frames_done), 32'd3);
    check("coin_ready", 32'(s_ready), 32'd1);
    set_exp(16'h1000, 1'b1, FW);
    check_frame("f2");

    // ack F2, then a stray ack with nothing presented
    ack_pulse();
    check("ack2_valid", 32'(frame_valid), 32'd0);
    ack_pulse();
    $display("stray ack applied");
    check("stray_valid", 32'(frame_valid), 32'd0);
    check("stray_done", 32'(frames_done), 32'd3);
    check("stray_ready", 32'(s_ready), 32'd1);

    // short frame lands in bank1, which still holds 0xFFFF
    short_cnt = 0;
    send_frame(16'hAAAA, 1'b0, 10, 1'b0);
    pad = 0;
    while (!s_ready && pad < 400) begin
      pad++;
      @(negedge clk);
    end
    $display("short frame padded over %0d cycles", pad);
    check("short_pad_cycles", 32'(pad), 32'd246);
    check("short_pulses", 32'(short_cnt), 32'd1);
    check("short_valid", 32'(frame_valid), 32'd1);
    check("short_done", 32'(frames_done), 32'd4);
    set_exp(16'hAAAA, 1'b0, 10);
    check_frame("short");
    ack_pulse();

    // long frame: 260 words, the last four dropped without stalling
    long_cnt = 0;
    stall_cnt = 0;
    send_frame(16'h2000, 1'b1, 260, 1'b0);
    $display("long frame sent, long pulses=%0d", long_cnt);
    check("long_pulses", 32'(long_cnt), 32'd1);
    check("long_stalls", 32'(stall_cnt), 32'd0);
    check("long_valid", 32'(frame_valid), 32'd1);
    check("long_done", 32'(frames_done), 32'd5);
    set_exp(16'h2000, 1'b1, FW);
    check_frame("long");

    // next frame must start at index 0
    send_frame(16'h3000, 1'b1, FW, 1'b0);
    check("after_long_done", 32'(frames_done), 32'd6);
    ack_pulse();
    $display("frame after long presented");
    check("after_long_valid", 32'(frame_valid), 32'd1);
    set_exp(16'h3000, 1'b1, FW);
    check_frame("after_long");

    // reset in the middle of a frame
    for (int i = 0; i < 100; i++) send(16'h5000 + 16'(i), 1'b0, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    $display("mid-frame reset asserted");
    check("mrst_valid", 32'(frame_valid), 32'd0);
    check("mrst_ready", 32'(s_ready), 32'd0);
    check("mrst_done", 32'(frames_done), 32'd0);
    check("mrst_short", 32'(short_frame), 32'd0);
    check("mrst_long", 32'(long_frame), 32'd0);
    check("mrst_data", 32'(|frame_data), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(16'h4000, 1'b1, FW, 1'b0);
    $display("fresh frame after reset loaded");
    check("fresh_valid", 32'(frame_valid), 32'd1);
    check("fresh_done", 32'(frames_done), 32'd1);
    set_exp(16'h4000, 1'b1, FW);
    check_frame("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
